// File: rtl/ysyx_22050612_idu_pipe.sv
// Instruction-decode stage: decodes {pc, inst} beats from IF and holds them in a
// two-entry elastic buffer (output register plus skid register) towards EX.
module ysyx_22050612_idu_pipe #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_inst,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [6:0]      out_opc,
  output logic [2:0]      out_fmt,
  output logic [XLEN-1:0] out_imm,
  output logic            out_illegal,
  output logic            out_ebreak,
  output logic            halted
);

  localparam logic [2:0] FMT_R    = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_NONE = 3'd6;
  localparam bit IS64 = (XLEN == 64);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic [2:0]      fmt;
    logic [XLEN-1:0] imm;
    logic            illegal;
    logic            ebreak;
  } beat_t;

  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [6:0]      opc;
  logic [2:0]      fmt_raw;
  logic            legal;
  logic            shamt_hi_ok;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  beat_t           dec;

  assign f3  = in_inst[14:12];
  assign f7  = in_inst[31:25];
  assign opc = in_inst[6:0];

  assign imm_i = XLEN'($signed(in_inst[31:20]));
  assign imm_s = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
  assign imm_b = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({in_inst[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0}));

  // RV32 shift amounts are 5 bits, so inst[25] must stay clear there.
  assign shamt_hi_ok = IS64 || !in_inst[25];

  always_comb begin
    fmt_raw = FMT_NONE;
    legal   = 1'b0;
    case (opc)
      7'b0110111, 7'b0010111: begin fmt_raw = FMT_U; legal = 1'b1; end
      7'b1101111:             begin fmt_raw = FMT_J; legal = 1'b1; end
      7'b1100111:             begin fmt_raw = FMT_I; legal = (f3 == 3'b000); end
      7'b1100011:             begin fmt_raw = FMT_B; legal = (f3 != 3'b010) && (f3 != 3'b011); end
      7'b0000011: begin
        fmt_raw = FMT_I;
        legal   = (f3 != 3'b111) && (IS64 || ((f3 != 3'b011) && (f3 != 3'b110)));
      end
      7'b0100011: begin
        fmt_raw = FMT_S;
        legal   = (f3 <= 3'b010) || ((f3 == 3'b011) && IS64);
      end
      7'b0010011: begin
        fmt_raw = FMT_I;
        case (f3)
          3'b001:  legal = (in_inst[31:26] == 6'b000000) && shamt_hi_ok;
          3'b101:  legal = ((in_inst[31:26] == 6'b000000) || (in_inst[31:26] == 6'b010000))
                           && shamt_hi_ok;
          default: legal = 1'b1;
        endcase
      end
      7'b0110011: begin
        fmt_raw = FMT_R;
        legal   = (f7 == 7'b0000000) || (f7 == 7'b0000001) ||
                  ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
      end
      7'b0011011: begin fmt_raw = FMT_I; legal = IS64; end
      7'b0111011: begin fmt_raw = FMT_R; legal = IS64; end
      7'b1110011: legal = (in_inst == 32'h0000_0073) || (in_inst == 32'h0010_0073);
      default:    legal = 1'b0;
    endcase
  end

  always_comb begin
    dec.pc      = in_pc;
    dec.inst    = in_inst;
    dec.illegal = !legal;
    dec.ebreak  = (in_inst == 32'h0010_0073);
    dec.fmt     = legal ? fmt_raw : FMT_NONE;
    case (dec.fmt)
      FMT_I:   dec.imm = imm_i;
      FMT_S:   dec.imm = imm_s;
      FMT_B:   dec.imm = imm_b;
      FMT_U:   dec.imm = imm_u;
      FMT_J:   dec.imm = imm_j;
      default: dec.imm = '0;
    endcase
  end

  beat_t out_q, out_d, skid_q, skid_d;
  logic  out_valid_q, out_valid_d;
  logic  skid_valid_q, skid_valid_d;
  logic  halted_q, halted_d;
  logic  accept, out_free;

  assign in_ready = !skid_valid_q && !halted_q;
  assign accept   = in_valid && in_ready && !flush;
  assign out_free = !out_valid_q || out_ready;

  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    halted_d     = halted_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      if (accept && dec.ebreak) halted_d = 1'b1;
      if (out_free) begin
        // Skid holds the older beat, so it always refills the output first.
        if (skid_valid_q) begin
          out_d        = skid_q;
          out_valid_d  = 1'b1;
          skid_valid_d = 1'b0;
        end else begin
          out_valid_d = accept;
          if (accept) out_d = dec;
        end
      end else if (accept) begin
        skid_d       = dec;
        skid_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      halted_q     <= halted_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_pc      = out_q.pc;
  assign out_rd      = out_q.inst[11:7];
  assign out_rs1     = out_q.inst[19:15];
  assign out_rs2     = out_q.inst[24:20];
  assign out_funct3  = out_q.inst[14:12];
  assign out_funct7  = out_q.inst[31:25];
  assign out_opc     = out_q.inst[6:0];
  assign out_fmt     = out_q.fmt;
  assign out_imm     = out_q.imm;
  assign out_illegal = out_q.illegal;
  assign out_ebreak  = out_q.ebreak;
  assign halted      = halted_q;

endmodule

// File: tb/tb_ysyx_22050612_idu_pipe.sv
// Directed bench for the decode stage: one XLEN=64 and one XLEN=32 instance
// sharing clock, reset, flush and out_ready.
module tb_ysyx_22050612_idu_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0, in_ready, flush = 1'b0, out_valid, out_ready = 1'b0;
  logic [63:0] in_pc = '0, out_pc, out_imm;
  logic [31:0] in_inst = '0;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [2:0]  out_funct3, out_fmt;
  logic [6:0]  out_funct7, out_opc;
  logic        out_illegal, out_ebreak, halted;

  logic        v32 = 1'b0, rdy32, ov32;
  logic [31:0] pc32 = '0, inst32 = '0, opc32_pc, imm32;
  logic [4:0]  rd32, rs1_32, rs2_32;
  logic [2:0]  f3_32, fmt32;
  logic [6:0]  f7_32, opc32;
  logic        ill32, ebr32, halt32;

  int checks = 0;
  int errors = 0;

  ysyx_22050612_idu_pipe #(.XLEN(64)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_inst(in_inst), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_funct3(out_funct3), .out_funct7(out_funct7), .out_opc(out_opc), .out_fmt(out_fmt),
    .out_imm(out_imm), .out_illegal(out_illegal), .out_ebreak(out_ebreak), .halted(halted)
  );

  ysyx_22050612_idu_pipe #(.XLEN(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_ready(rdy32), .in_pc(pc32),
    .in_inst(inst32), .flush(flush), .out_valid(ov32), .out_ready(out_ready),
    .out_pc(opc32_pc), .out_rd(rd32), .out_rs1(rs1_32), .out_rs2(rs2_32),
    .out_funct3(f3_32), .out_funct7(f7_32), .out_opc(opc32), .out_fmt(fmt32),
    .out_imm(imm32), .out_illegal(ill32), .out_ebreak(ebr32), .halted(halt32)
  );

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %0b want 0", halted); end
    checks++; if (out_pc !== 64'h0 || out_imm !== 64'h0 || out_fmt !== 3'd0) begin
      errors++; $display("FAIL reset_fields got pc=%h imm=%h fmt=%0d want 0", out_pc, out_imm, out_fmt); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    out_ready = 1'b1; in_valid = 1'b1; in_pc = 64'h8000_0000; in_inst = 32'hfff0_0093;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %0b want 1", out_valid); end
    checks++; if (out_rd !== 5'd1 || out_rs1 !== 5'd0) begin
      errors++; $display("FAIL basic_regs got rd=%0d rs1=%0d want rd=1 rs1=0", out_rd, out_rs1); end
    checks++; if (out_fmt !== 3'd1) begin errors++; $display("FAIL basic_fmt got %0d want 1", out_fmt); end
    checks++; if (out_imm !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL basic_imm got %h want ffffffffffffffff", out_imm); end
    checks++; if (out_illegal !== 1'b0) begin errors++; $display("FAIL basic_illegal got %0b want 0", out_illegal); end
    checks++; if (out_pc !== 64'h8000_0000) begin errors++; $display("FAIL basic_pc got %h want 80000000", out_pc); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain got %0b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1; in_pc = 64'h1000; in_inst = 32'h0080_00ef;
    tick();
    in_pc = 64'h1004; in_inst = 32'hfe00_0ee3;
    checks++; if (out_valid !== 1'b1 || out_fmt !== 3'd5 || out_imm !== 64'd8) begin
      errors++; $display("FAIL b2b_jal got v=%0b fmt=%0d imm=%h want v=1 fmt=5 imm=8", out_valid, out_fmt, out_imm); end
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_fmt !== 3'd3 || out_imm !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      errors++; $display("FAIL b2b_beq got v=%0b fmt=%0d imm=%h want v=1 fmt=3 imm=fffffffffffffffc", out_valid, out_fmt, out_imm); end
    checks++; if (out_pc !== 64'h1004) begin errors++; $display("FAIL b2b_pc got %h want 1004", out_pc); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %0b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_valid = 1'b1; in_pc = 64'h100; in_inst = 32'h0000_0093;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready0 got %0b want 1", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_pc !== 64'h100 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_first got v=%0b pc=%h rdy=%0b want v=1 pc=100 rdy=1", out_valid, out_pc, in_ready); end
    in_pc = 64'h104; in_inst = 32'h0000_0113;
    tick();
    checks++; if (in_ready !== 1'b0 || out_pc !== 64'h100) begin
      errors++; $display("FAIL bp_full got rdy=%0b pc=%h want rdy=0 pc=100", in_ready, out_pc); end
    in_pc = 64'h108; in_inst = 32'h0000_0193;
    tick();
    checks++; if (in_ready !== 1'b0 || out_pc !== 64'h100 || out_rd !== 5'd1 || out_valid !== 1'b1) begin
      errors++; $display("FAIL bp_stall got rdy=%0b pc=%h rd=%0d v=%0b want rdy=0 pc=100 rd=1 v=1", in_ready, out_pc, out_rd, out_valid); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b1 || out_pc !== 64'h104 || out_rd !== 5'd2 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_second got v=%0b pc=%h rd=%0d rdy=%0b want v=1 pc=104 rd=2 rdy=1", out_valid, out_pc, out_rd, in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_pc !== 64'h108 || out_rd !== 5'd3) begin
      errors++; $display("FAIL bp_third got v=%0b pc=%h rd=%0d want v=1 pc=108 rd=3", out_valid, out_pc, out_rd); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %0b want 0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; in_pc = 64'h300; in_inst = 32'h0000_0093;
    tick();
    in_pc = 64'h304;
    tick();
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL flush_full got rdy=%0b v=%0b want rdy=0 v=1", in_ready, out_valid); end
    in_pc = 64'h308; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_clear got v=%0b rdy=%0b want v=0 rdy=1", out_valid, in_ready); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_absent got v=%0b pc=%h want v=0", out_valid, out_pc); end
    // A beat offered with in_ready=1 during flush is dropped as well.
    in_valid = 1'b1; in_pc = 64'h30c; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_drop got v=%0b want 0", out_valid); end
  endtask

  localparam logic [31:0] XI   [7] = '{32'h0010_009b, 32'h0200_9093, 32'h0011_3423, 32'h4010_5013,
                                       32'h0000_7003, 32'h4000_1033, 32'h0000_6003};
  localparam logic        XIL32[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  localparam logic        XIL64[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  localparam logic [2:0]  XF64 [7] = '{3'd1, 3'd1, 3'd2, 3'd1, 3'd6, 3'd6, 3'd1};
  localparam logic [63:0] XIM  [7] = '{64'd1, 64'd32, 64'd8, 64'h401, 64'd0, 64'd0, 64'd0};

  task automatic test_xlen();
    logic [63:0] imm_exp;
    logic [31:0] imm32_exp;
    logic [2:0]  fmt32_exp;
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; v32 = 1'b1; in_inst = XI[i]; inst32 = XI[i];
      in_pc = 64'h400 + 64'(i * 4); pc32 = 32'h400 + 32'(i * 4);
      imm_exp   = XIM[i];
      imm32_exp = XIL32[i] ? 32'h0 : imm_exp[31:0];
      fmt32_exp = XIL32[i] ? 3'd6 : XF64[i];
      tick();
      checks++; if (out_illegal !== XIL64[i] || out_fmt !== XF64[i] || out_imm !== imm_exp) begin
        errors++; $display("FAIL xlen64_%0d got ill=%0b fmt=%0d imm=%h want ill=%0b fmt=%0d imm=%h",
                           i, out_illegal, out_fmt, out_imm, XIL64[i], XF64[i], imm_exp); end
      checks++; if (ill32 !== XIL32[i] || fmt32 !== fmt32_exp || imm32 !== imm32_exp || ov32 !== 1'b1) begin
        errors++; $display("FAIL xlen32_%0d got v=%0b ill=%0b fmt=%0d imm=%h want v=1 ill=%0b fmt=%0d imm=%h",
                           i, ov32, ill32, fmt32, imm32, XIL32[i], fmt32_exp, imm32_exp); end
    end
    in_valid = 1'b0; v32 = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; in_valid = 1'b1; in_pc = 64'h500; in_inst = 32'h0000_0093;
    tick();
    tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_pc !== 64'h0) begin
      errors++; $display("FAIL rstmid_clear got v=%0b rdy=%0b pc=%h want v=0 rdy=1 pc=0", out_valid, in_ready, out_pc); end
    #3;
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_nobeat got %0b want 0", out_valid); end
  endtask

  task automatic test_halt();
    out_ready = 1'b1; in_valid = 1'b1; in_pc = 64'h200; in_inst = 32'h0010_0073;
    tick();
    in_pc = 64'h204; in_inst = 32'h0000_0013;
    checks++; if (out_valid !== 1'b1 || out_ebreak !== 1'b1 || out_fmt !== 3'd6 || out_illegal !== 1'b0) begin
      errors++; $display("FAIL halt_beat got v=%0b ebr=%0b fmt=%0d ill=%0b want v=1 ebr=1 fmt=6 ill=0", out_valid, out_ebreak, out_fmt, out_illegal); end
    checks++; if (halted !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL halt_set got halted=%0b rdy=%0b want halted=1 rdy=0", halted, in_ready); end
    tick();
    tick();
    tick();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL halt_block got v=%0b rdy=%0b want v=0 rdy=0", out_valid, in_ready); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (halted !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL halt_flush got halted=%0b rdy=%0b want halted=1 rdy=0", halted, in_ready); end
    rst_n = 1'b0;
    #1;
    checks++; if (halted !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL halt_reset got halted=%0b rdy=%0b want halted=0 rdy=1", halted, in_ready); end
    #3;
    rst_n = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_pc !== 64'h204 || out_ebreak !== 1'b0) begin
      errors++; $display("FAIL halt_resume got v=%0b pc=%h ebr=%0b want v=1 pc=204 ebr=0", out_valid, out_pc, out_ebreak); end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_xlen();
    test_reset_mid();
    test_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
